// File: rtl/bcd_calc_pkg.sv
// bcd_calc_pkg: shared definitions for the bcd_calc_scan calculator.
//   - SEG_*      : 7-segment codes {g,f,e,d,c,b,a}, active-high
//   - state_t    : control FSM states
//   - digit_t    : one display digit (BCD value plus blank / minus controls)
//   - calc_cd()  : number of BCD digits needed to hold a (w+1)-bit value, plus one spare
package bcd_calc_pkg;

   localparam logic [6:0] SEG_0     = 7'b0111111;
   localparam logic [6:0] SEG_1     = 7'b0000110;
   localparam logic [6:0] SEG_2     = 7'b1011011;
   localparam logic [6:0] SEG_3     = 7'b1001111;
   localparam logic [6:0] SEG_4     = 7'b1100110;
   localparam logic [6:0] SEG_5     = 7'b1101101;
   localparam logic [6:0] SEG_6     = 7'b1111101;
   localparam logic [6:0] SEG_7     = 7'b0000111;
   localparam logic [6:0] SEG_8     = 7'b1111111;
   localparam logic [6:0] SEG_9     = 7'b1100111;
   localparam logic [6:0] SEG_BLANK = 7'b0000000;
   localparam logic [6:0] SEG_MINUS = 7'b1000000;

   typedef enum logic [1:0] {
      StIdle,
      StConv,
      StLoad
   } state_t;

   typedef struct packed {
      logic       blank;
      logic       minus;
      logic [3:0] bcd;
   } digit_t;

   localparam digit_t DIGIT_ZERO  = '{blank: 1'b0, minus: 1'b0, bcd: 4'd0};
   localparam digit_t DIGIT_BLANK = '{blank: 1'b1, minus: 1'b0, bcd: 4'd0};

   // ceil((w+1) * 0.302) + 1, evaluated in integer arithmetic
   function automatic int unsigned calc_cd(input int unsigned w);
      return ((w + 1) * 302 + 999) / 1000 + 1;
   endfunction

endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: combinational BCD to 7-segment decoder.
//   bcd   in  4  BCD digit value (10..15 decode to blank)
//   blank in  1  force all segments off
//   minus in  1  show a minus sign (wins over blank and bcd)
//   seg   out 7  segments {g,f,e,d,c,b,a}, active-high
module seg7_decode
   import bcd_calc_pkg::*;
(
   input  logic [3:0] bcd,
   input  logic       blank,
   input  logic       minus,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_BLANK;
      if (minus) begin
         seg = SEG_MINUS;
      end else if (!blank) begin
         case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
         endcase
      end
   end

endmodule

// File: rtl/bcd_calc_scan.sv
// bcd_calc_scan: handshaked add/subtract calculator with iterative double-dabble BCD conversion
// and a scanned, multiplexed multi-digit 7-segment display.
//   clk       in   1       system clock, rising edge
//   rst       in   1       synchronous active-high reset
//   a, b      in   W       unsigned operands
//   s         in   1       0 = a+b, 1 = a-b
//   in_valid  in   1       operands valid
//   in_ready  out  1       idle, next operands accepted
//   lcd       out  7       segments of the currently scanned digit {g,f,e,d,c,b,a}
//   an        out  DIGITS  one-hot digit enable, bit 0 = units
//   lcd_o     out  1       displayed result is out of range (all digits blank)
//   done      out  1       one-cycle pulse after a new result is loaded
// Build option: define NEG_DISPLAY_EN to show small negative results with a leading minus sign;
// otherwise every negative result is reported as out of range.
module bcd_calc_scan
   import bcd_calc_pkg::*;
#(
   parameter int unsigned W        = 8,
   parameter int unsigned DIGITS   = 2,
   parameter int unsigned SCAN_DIV = 1024
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [W-1:0]      a,
   input  logic [W-1:0]      b,
   input  logic              s,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [6:0]        lcd,
   output logic [DIGITS-1:0] an,
   output logic              lcd_o,
   output logic              done
);

   localparam int unsigned CD = calc_cd(W);                     // BCD digits produced
   localparam int unsigned ND = (CD > DIGITS) ? CD : DIGITS;    // digits examined at load
   localparam int unsigned SW = 4 * CD + W + 1;                 // dabble shift register width
   localparam int unsigned CW = $clog2(W + 1) + 1;
   localparam int unsigned PW = $clog2(SCAN_DIV);
   localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   state_t          state_q;
   logic [SW-1:0]   sh_q;
   logic            neg_q;
   logic [CW-1:0]   cnt_q;
   logic            done_q;
   logic            lcd_o_q;
   digit_t          disp_q [DIGITS];
   logic [PW-1:0]   presc_q;
   logic [IW-1:0]   idx_q;

   // Operand stage: sum, or magnitude of the difference with its sign kept aside.
   logic [W:0] r;
   logic       neg;

   always_comb begin
      neg = s && (a < b);
      if (!s) begin
         r = {1'b0, a} + {1'b0, b};
      end else if (neg) begin
         r = {1'b0, b} - {1'b0, a};
      end else begin
         r = {1'b0, a} - {1'b0, b};
      end
   end

   // One double-dabble step: add 3 to every BCD nibble >= 5, then shift left by one.
   logic [SW-1:0] adj;
   logic [SW-1:0] step;

   always_comb begin
      adj = sh_q;
      for (int unsigned i = 0; i < CD; i++) begin
         if (adj[W + 1 + 4 * i +: 4] > 4'd4) begin
            adj[W + 1 + 4 * i +: 4] = adj[W + 1 + 4 * i +: 4] + 4'd3;
         end
      end
      step = adj << 1;
   end

   // BCD digits of the finished conversion, zero-padded when DIGITS exceeds CD.
   logic [3:0] bcd [ND];

   for (genvar g = 0; g < ND; g++) begin : g_bcd
      if (g < CD) begin : g_real
         assign bcd[g] = sh_q[W + 1 + 4 * g +: 4];
      end else begin : g_pad
         assign bcd[g] = 4'd0;
      end
   end

   // Display image for the LOAD edge.
   digit_t      disp_d [DIGITS];
   logic        hi_nz;
   logic        ovf;
   int unsigned top;

   always_comb begin
      hi_nz = 1'b0;
      for (int unsigned i = DIGITS; i < ND; i++) begin
         if (bcd[i] != 4'd0) hi_nz = 1'b1;
      end

      // Highest nonzero displayable digit; units stays visible even for a zero result.
      top = 0;
      for (int unsigned i = 0; i < DIGITS; i++) begin
         if (bcd[i] != 4'd0) top = i;
      end

`ifdef NEG_DISPLAY_EN
      // The minus sign needs a free digit above the magnitude.
      ovf = hi_nz || (neg_q && (bcd[DIGITS-1] != 4'd0));
`else
      ovf = hi_nz || neg_q;
`endif

      for (int unsigned i = 0; i < DIGITS; i++) begin
         disp_d[i]       = DIGIT_BLANK;
         disp_d[i].bcd   = bcd[i];
         disp_d[i].blank = ovf || (i > top);
`ifdef NEG_DISPLAY_EN
         disp_d[i].minus = !ovf && neg_q && (i == top + 1);
`endif
      end
   end

   // Control FSM and result registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         sh_q    <= '0;
         neg_q   <= 1'b0;
         cnt_q   <= '0;
         done_q  <= 1'b0;
         lcd_o_q <= 1'b0;
         for (int unsigned i = 0; i < DIGITS; i++) begin
            disp_q[i] <= (i == 0) ? DIGIT_ZERO : DIGIT_BLANK;
         end
      end else begin
         done_q <= 1'b0;
         case (state_q)
            StIdle: begin
               if (in_valid) begin
                  sh_q    <= {{(4 * CD){1'b0}}, r};
                  neg_q   <= neg;
                  cnt_q   <= '0;
                  state_q <= StConv;
               end
            end
            StConv: begin
               sh_q  <= step;
               cnt_q <= cnt_q + CW'(1);
               // W+1 shift steps in total
               if (cnt_q == CW'(W)) state_q <= StLoad;
            end
            StLoad: begin
               disp_q  <= disp_d;
               lcd_o_q <= ovf;
               done_q  <= 1'b1;
               state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   // Digit scan: free-running, independent of result loads.
   always_ff @(posedge clk) begin
      if (rst) begin
         presc_q <= '0;
         idx_q   <= '0;
      end else if (presc_q == PW'(SCAN_DIV - 1)) begin
         presc_q <= '0;
         idx_q   <= (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);
      end else begin
         presc_q <= presc_q + PW'(1);
      end
   end

   always_comb begin
      an        = '0;
      an[idx_q] = 1'b1;
   end

   digit_t sel;
   assign sel = disp_q[idx_q];

   seg7_decode u_seg7_decode (
      .bcd   (sel.bcd),
      .blank (sel.blank),
      .minus (sel.minus),
      .seg   (lcd)
   );

   assign in_ready = (state_q == StIdle);
   assign lcd_o    = lcd_o_q;
   assign done     = done_q;

endmodule

// File: doc/bcd_calc_scan.md
# bcd_calc_scan

Sequential, parametrised add/subtract calculator. It accepts two W-bit unsigned operands through a valid/ready handshake and computes the sum or difference. It converts the result to BCD with an iterative shift-add-3 (double-dabble) engine, then drives a DIGITS-wide multiplexed 7-segment display with an overflow flag. It generalises the single-digit adder/7-segment display path (ten or more gives blank plus overflow) to multi-digit output, handshaked input and scanned digits.

## Interface
- W, 8, operand width in bits
- DIGITS, 2, number of displayed digits
- SCAN_DIV, 1024, clocks per digit-scan step (≥2)
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- a  in  W  operand A, unsigned
- b  in  W  operand B, unsigned
- s  in  1  operation select: 0 = a+b, 1 = a−b
- in_valid  in  1  operands/op valid
- in_ready  out  1  block idle, can accept
- lcd  out  7  segments {g,f,e,d,c,b,a}, active-high
- an  out  DIGITS  one-hot digit enable, bit 0 = units
- lcd_o  out  1  overflow / out-of-range flag for displayed result
- done  out  1  one-cycle pulse: new result loaded

## Operation
- Reset: state IDLE, in_ready=1, done=0, lcd_o=0, scan index 0, an=…001, display registers = digit0 "0", others blank. As a result, lcd=0111111 after reset.
- States:
  - IDLE → CONV on in_valid && in_ready.
  - CONV holds W+1 cycles, one shift step per cycle.
  - CONV → LOAD.
  - LOAD → IDLE.
- Acceptance latches r = a+b (W+1 bits) or |a−b| with neg = (s && a<b).
- Conversion: double-dabble of r into CD = ceil((W+1)·0.302)+1 BCD digits.
- Overflow (lcd_o=1, all digits blank 0000000): any BCD digit at index ≥DIGITS is nonzero, or neg=1 (subject to Configuration).
- Leading zeros are blanked. The units digit always shows, so a zero result shows "0".
- Segment codes:
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110
  - 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1100111
  - blank=0000000, minus=1000000
- Scan:
  - Prescaler counts 0..SCAN_DIV−1. On wrap the digit index increments, and DIGITS−1 wraps to 0.
  - an = one-hot(index) and lcd = segments of that digit, both decoded combinationally from registers.
- in_valid while in_ready=0 is ignored; upstream holds its data.

## Timing
- Acceptance edge E0 latches r; CONV shift edges are E1..E(W+1); at E(W+2) (LOAD) the display registers and lcd_o update atomically.
- done=1 and in_ready=1 in the cycle after E(W+2). Latency is W+2 clocks; throughput is one op per W+3 clocks.
- in_ready=0 from the cycle after E0 until done.
- Display update never disturbs the scan index or prescaler.
- rst mid-conversion aborts the operation: no done, and all outputs return to reset values the next cycle.
- rst has priority over in_valid on the same edge.

## Configuration
- NEG_DISPLAY_EN defined:
  - A negative result with magnitude ≤ 10^(DIGITS−1)−1 displays a minus sign on the digit directly above the highest nonzero digit, with lcd_o=0.
  - A larger negative magnitude gives overflow.
- Undefined: any neg=1 result gives overflow (lcd_o=1, all blank).

## Structure
- Package bcd_calc_pkg holds:
  - segment constants SEG_0..SEG_9, SEG_BLANK, SEG_MINUS
  - state enum typedef (IDLE, CONV, LOAD)
  - a function computing CD from W
- One sub-module, seg7_decode: 4-bit BCD plus blank/minus controls → 7-bit segments, combinational. It is instanced once on the scan-selected digit.

## Test plan
(W=8, DIGITS=2, SCAN_DIV=4)
- Reset, then sample → an=01, lcd=0111111, lcd_o=0, in_ready=1, done=0. an toggles to 10 after 4 clocks.
- a=7, b=5, s=0 → done exactly 10 clocks after acceptance. Units digit lcd=1011011, tens digit 0000110, lcd_o=0.
- a=4, b=0, s=0 → units 1100110, tens blank 0000000 (leading-zero suppression).
- a=60, b=40, s=0 (100) → lcd_o=1, both digits 0000000. Then a=9, b=0 → lcd_o=0, units 1100111.
- a=3, b=8, s=1:
  - Without the macro → lcd_o=1, all blank.
  - With NEG_DISPLAY_EN → tens 1000000, units 1101101, lcd_o=0.
- in_valid pulsed with new operands during CONV → ignored, and the first result is unchanged. rst asserted at cycle 4 of CONV → no done, reset display restored, next handshake accepted normally.
